acc_multi: RTL and testbench

Parametrised sequential successor to the combinational acc cell. Holds CHANNELS independent unsigned accumulators, each fed through a valid/ready input stream. Each beat selects wrap or saturate arithmetic, and overflow flags are sticky per channel. On request, a DUMP sequence streams every channel out over a valid/ready output port. Sits between a sample source and a downstream checker/logger in the ADDAC datapath.

---
 rtl/acc_pkg.sv | 26 ++
 rtl/acc_lane.sv | 51 +++++
 rtl/acc_multi.sv | 101 ++++++++++
 tb/tb_acc_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and the add/saturate helper for the multi-channel accumulator.
package acc_pkg;

  typedef enum logic {ACC_S, DUMP_S} acc_state_t;

  // Widest accumulator the helper supports; callers pass their real width.
  localparam int ADD_MAX_W = 32;

  // Returns {ovf_bit, new_acc}; only the low 'width' bits of new_acc are meaningful.
  function automatic logic [ADD_MAX_W:0] acc_add(input logic [ADD_MAX_W-1:0] acc,
                                                 input logic [ADD_MAX_W-1:0] din,
                                                 input int unsigned          width,
                                                 input logic                 sat);
    logic [ADD_MAX_W:0] sum;
    logic [ADD_MAX_W:0] mask;
    logic [ADD_MAX_W:0] res;
    logic               carry;
    sum   = {1'b0, acc} + {1'b0, din};
    carry = sum[width];
    mask  = ({{ADD_MAX_W{1'b0}}, 1'b1} << width) - 1'b1;
    if (sat && carry) res = mask;
    else              res = sum & mask;
    return {carry, res[ADD_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator channel: register, wrap/saturate add and sticky overflow flag.
module acc_lane
  import acc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     din_i,
  input  logic                 sat_i,
  input  logic                 clr_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ADD_MAX_W:0]   add_r;
  logic [ADD_MAX_W-1-ACC_WIDTH:0] unused_hi;

  assign add_r     = acc_add(ADD_MAX_W'(acc_q), ADD_MAX_W'(din_i), ACC_WIDTH, sat_i);
  assign unused_hi = add_r[ADD_MAX_W-1:ACC_WIDTH];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      acc_d = add_r[ACC_WIDTH-1:0];
      ovf_d = ovf_q | add_r[ADD_MAX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_multi.sv
// Multi-channel accumulator with valid/ready input and a streamed dump of all channels.
module acc_multi
  import acc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int CHANNELS    = 4,
  parameter int CLR_ON_DUMP = 1,
  localparam int CH_W       = $clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [CH_W-1:0]      in_ch,
  input  logic                 sat_mode,
  input  logic                 clr,
  input  logic                 dump,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_last,
  output logic [CHANNELS-1:0]  ovf,
  output logic                 busy
);

  acc_state_t          state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic                accept;
  logic                out_hs;
  logic                clr_all;
  logic                last_idx;
  logic [ACC_WIDTH-1:0] acc_arr [CHANNELS];

  assign in_ready = reset && (state_q == ACC_S) && !clr;
  assign accept   = in_valid && in_ready;
  assign clr_all  = (state_q == ACC_S) && clr;
  assign last_idx = (idx_q == CH_W'(CHANNELS - 1));
  assign out_hs   = out_valid && out_ready;

  // Out-of-range in_ch matches no lane, so such beats are consumed without effect.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic dump_clr;
    assign dump_clr = (CLR_ON_DUMP != 0) && out_hs && (idx_q == CH_W'(g));
    acc_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en_i  (accept && (in_ch == CH_W'(g))),
      .din_i (in_data),
      .sat_i (sat_mode),
      .clr_i (clr_all || dump_clr),
      .acc_o (acc_arr[g]),
      .ovf_o (ovf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACC_S;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ACC_S: begin
        if (!clr && dump) state_d = DUMP_S;
      end
      DUMP_S: begin
        if (out_hs) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = ACC_S;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ACC_S;
    endcase
  end

  always_comb begin
    out_valid = (state_q == DUMP_S);
    busy      = (state_q == DUMP_S);
    out_ch    = idx_q;
    out_data  = acc_arr[idx_q];
    out_last  = last_idx;
  end

endmodule

// File: tb/tb_acc_multi.sv
// Scoreboard bench for acc_multi: stimulus pushes expected dump words, a monitor pops on handshakes.
module tb_acc_multi;

  localparam int WIDTH = 8;
  localparam int ACC_WIDTH = 10;
  localparam int CHANNELS = 4;
  localparam int CH_W = 2;

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [ACC_WIDTH-1:0] data;
    logic                 last;
  } word_t;

  logic                 clk = 1'b0;
  logic                 reset, in_valid, in_ready, sat_mode, clr, dump;
  logic [WIDTH-1:0]     in_data;
  logic [CH_W-1:0]      in_ch;
  logic                 out_valid, out_ready, out_last, busy;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CH_W-1:0]      out_ch;
  logic [CHANNELS-1:0]  ovf;

  word_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    hs_cnt = 0;

  acc_multi #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CHANNELS(CHANNELS), .CLR_ON_DUMP(1)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .sat_mode(sat_mode), .clr(clr), .dump(dump),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a word handshakes at the next posedge when valid&&ready are seen here.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got ch=%0d data=%0d expected none", out_ch, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_ch", int'(out_ch), int'(e.ch));
          chk("word_data", int'(out_data), int'(e.data));
          chk("word_last", int'(out_last), int'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int d0, input int d1, input int d2, input int d3);
    int d[4];
    word_t w;
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      w.ch = CH_W'(i);
      w.data = ACC_WIDTH'(d[i]);
      w.last = (i == 3);
      exp_q.push_back(w);
    end
  endtask

  task automatic beat(input int ch, input int data, input logic sat);
    in_valid = 1'b1;
    in_ch = CH_W'(ch);
    in_data = WIDTH'(data);
    sat_mode = sat;
    tick();
    in_valid = 1'b0;
  endtask

  // Assert dump for one cycle (optionally with a beat already set up) and drain with ready=1.
  task automatic dump_drain();
    int n;
    out_ready = 1'b1;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: got busy=1 expected busy=0");
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [6:0] pat;
    int pch, pd, hs0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0; sat_mode = 1'b0;
    clr = 1'b0; dump = 1'b0; out_ready = 1'b0;

    // 1. reset with in_valid high
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready_async", int'(in_ready), 0);
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    push4(0, 0, 0, 0);
    dump_drain();

    // 2. wrap: 5 x 255 on ch1 -> 1275 mod 1024 = 251
    for (int i = 0; i < 5; i++) beat(1, 8'hFF, 1'b0);
    chk("wrap_ovf", int'(ovf), 4'b0010);
    push4(0, 251, 0, 0);
    dump_drain();
    chk("wrap_ovf_cleared", int'(ovf), 0);

    // 3. saturate: 6 x 200 on ch2 -> 1023; 3 on ch0
    for (int i = 0; i < 6; i++) beat(2, 200, 1'b1);
    beat(0, 3, 1'b1);
    chk("sat_ovf", int'(ovf), 4'b0100);
    push4(3, 0, 1023, 0);
    dump_drain();
    chk("sat_ovf_cleared", int'(ovf), 0);

    // 4. backpressure on a dump of ch3=77; in_valid held high but must be ignored
    beat(3, 77, 1'b0);
    push4(0, 0, 0, 77);
    pat = 7'b1101001;   // bit i = out_ready in cycle i: 1,0,0,1,0,1,1
    hs0 = hs_cnt;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      in_valid = (i < 6);
      in_ch = 2'd0;
      in_data = 8'd5;
      #1;
      chk("bp_busy", int'(busy), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      pch = int'(out_ch);
      pd = int'(out_data);
      tick();
      if (!pat[i]) begin
        chk("bp_stable_ch", int'(out_ch), pch);
        chk("bp_stable_data", int'(out_data), pd);
      end
    end
    in_valid = 1'b0;
    chk("bp_handshakes", hs_cnt - hs0, 4);
    chk("bp_done_busy", int'(busy), 0);
    chk("bp_done_valid", int'(out_valid), 0);
    push4(0, 0, 0, 0);
    dump_drain();

    // 5a. clr with a concurrent beat: beat refused, ch1 cleared
    beat(1, 5, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd9;
    #1;
    chk("clr_in_ready", int'(in_ready), 0);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    // 5b. dump with an accepted beat in the same cycle
    in_valid = 1'b1; in_ch = 2'd0; in_data = 8'd9; sat_mode = 1'b0;
    push4(9, 0, 0, 0);
    dump_drain();
    // 5c. clr with dump: stays in ACC
    clr = 1'b1;
    dump = 1'b1;
    tick();
    clr = 1'b0;
    dump = 1'b0;
    chk("clr_dump_busy", int'(busy), 0);
    chk("clr_dump_valid", int'(out_valid), 0);

    // 6. reset after two dump handshakes
    beat(0, 10, 1'b0);
    beat(1, 20, 1'b0);
    for (int i = 0; i < 6; i++) beat(3, 200, 1'b1);
    chk("pre_rst_ovf", int'(ovf), 4'b1000);
    exp_q.push_back('{ch: 2'd0, data: 10'd10, last: 1'b0});
    exp_q.push_back('{ch: 2'd1, data: 10'd20, last: 1'b0});
    out_ready = 1'b1;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    tick();
    tick();
    chk("mid_dump_ch", int'(out_ch), 2);
    out_ready = 1'b0;
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_ch", int'(out_ch), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    chk("mid_rst_queue", exp_q.size(), 0);
    push4(0, 0, 0, 0);
    dump_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
